store_sequence_monitor: RTL and testbench

- Synthesizable, parametrised checker that watches the processor's data-memory store port (memwrite/dataadr/writedata).
- Decides pass/fail against a loadable table of expected (address, data) stores, ordered or unordered.
- Masked scratch-address window is ignored; cycle timeout bounds the run.
- Sits beside the core top in simulation and FPGA self-test builds; drives status LEDs/registers.

---
 rtl/store_sequence_monitor.sv | 170 +++++++++++++++++
 tb/tb_store_sequence_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_sequence_monitor.sv
// Watches the data-memory store port and judges it against a loadable table of
// expected (address, data) stores; reports PASS, FAIL (mismatch) or TIMEOUT.
module store_sequence_monitor #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       NUM_EXP      = 4,
  parameter int unsigned       IDX_W        = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  parameter int unsigned       CNT_W        = 16,
  parameter int unsigned       TIMEOUT      = 4096,
  parameter logic [ADDR_W-1:0] SCRATCH_ADDR = ADDR_W'(80),
  parameter logic [ADDR_W-1:0] SCRATCH_MASK = '1,
  parameter bit                ORDERED      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [IDX_W:0]    exp_count,
  input  logic              start,
  input  logic              clear,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W:0]    match_count,
  output logic [CNT_W-1:0]  cycles,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

  state_e              state_q, state_d;
  logic [IDX_W:0]      n_q, n_d, mc_q, mc_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [NUM_EXP-1:0]  valid_q, valid_d, hit_q, hit_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic [DATA_W-1:0]   fdata_q, fdata_d;
  logic [ADDR_W-1:0]   tab_addr_q [NUM_EXP];
  logic [DATA_W-1:0]   tab_data_q [NUM_EXP];

  logic                tab_wr, match, scratch, timeout_now;
  logic [IDX_W-1:0]    match_idx, ord_idx;
  logic [IDX_W:0]      n_sat;

  assign tab_wr      = (state_q == S_IDLE) && exp_we && !clear &&
                       ({1'b0, exp_idx} < (IDX_W+1)'(NUM_EXP));
  assign n_sat       = (exp_count > (IDX_W+1)'(NUM_EXP)) ? (IDX_W+1)'(NUM_EXP) : exp_count;
  assign scratch     = (dataadr & SCRATCH_MASK) == (SCRATCH_ADDR & SCRATCH_MASK);
  assign timeout_now = (cyc_q == CNT_W'(TIMEOUT - 1));
  assign ord_idx     = mc_q[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (tab_wr) begin
      tab_addr_q[exp_idx] <= exp_addr;
      tab_data_q[exp_idx] <= exp_data;
    end
  end

  // Ordered mode only looks at the next entry; unordered takes the lowest unhit hit.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    if (ORDERED) begin
      match_idx = ord_idx;
      match     = (mc_q < n_q) && valid_q[ord_idx] &&
                  (tab_addr_q[ord_idx] == dataadr) && (tab_data_q[ord_idx] == writedata);
    end else begin
      for (int unsigned i = 0; i < NUM_EXP; i++) begin
        if (!match && valid_q[i] && !hit_q[i] && ((IDX_W+1)'(i) < n_q) &&
            (tab_addr_q[i] == dataadr) && (tab_data_q[i] == writedata)) begin
          match     = 1'b1;
          match_idx = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      mc_q    <= '0;
      cyc_q   <= '0;
      valid_q <= '0;
      hit_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      mc_q    <= mc_d;
      cyc_q   <= cyc_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    mc_d    = mc_q;
    cyc_d   = cyc_q;
    valid_d = valid_q;
    hit_d   = hit_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (tab_wr) valid_d[exp_idx] = 1'b1;
    if (clear) begin
      state_d = S_IDLE;
      mc_d    = '0;
      cyc_d   = '0;
      hit_d   = '0;
      faddr_d = '0;
      fdata_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          n_d     = n_sat;
          mc_d    = '0;
          cyc_d   = '0;
          hit_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
          state_d = (n_sat == '0) ? S_PASS : S_RUN;
        end
        S_RUN: begin
          cyc_d = cyc_q + 1'b1;
          if (memwrite && match) begin
            mc_d = mc_q + 1'b1;
            if (!ORDERED) hit_d[match_idx] = 1'b1;
            if (mc_q + 1'b1 == n_q) state_d = S_PASS;
            else if (timeout_now)   state_d = S_TIMEOUT;
          end else if (memwrite && !scratch) begin
            state_d = S_FAIL;
            faddr_d = dataadr;
            fdata_d = writedata;
          end else if (timeout_now) begin
            state_d = S_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done      = 1'b0;
    pass      = 1'b0;
    fail_code = 2'd0;
    unique case (state_q)
      S_PASS:    begin done = 1'b1; pass = 1'b1; end
      S_FAIL:    begin done = 1'b1; fail_code = 2'd1; end
      S_TIMEOUT: begin done = 1'b1; fail_code = 2'd2; end
      default: ;
    endcase
  end

  assign match_count = mc_q;
  assign cycles      = cyc_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;

endmodule

// File: tb/tb_store_sequence_monitor.sv
// Drives an ordered and an unordered monitor with the same store stream and
// scores each verdict against hand-computed expectations queued per instance.
module tb_store_sequence_monitor;

  localparam int unsigned IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             exp_we, start, clear, memwrite;
  logic [IDX_W-1:0] exp_idx;
  logic [31:0]      exp_addr, exp_data, dataadr, writedata;
  logic [IDX_W:0]   exp_count;

  logic             done [2];
  logic             pass [2];
  logic [1:0]       fcode [2];
  logic [IDX_W:0]   mcnt [2];
  logic [15:0]      cyc [2];
  logic [31:0]      faddr [2];
  logic [31:0]      fdata [2];

  typedef struct {
    bit       pass;
    bit [1:0] fc;
    int       mc;
    int       cyc;
    int       fa;
    int       fd;
  } res_t;

  res_t q0 [$];
  res_t q1 [$];
  int   checks = 0;
  int   errors = 0;
  logic done_prev [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  store_sequence_monitor #(.NUM_EXP(4), .TIMEOUT(16), .ORDERED(1'b1)) u_ord (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_count(exp_count), .start(start), .clear(clear),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[0]), .pass(pass[0]), .fail_code(fcode[0]), .match_count(mcnt[0]),
    .cycles(cyc[0]), .fail_addr(faddr[0]), .fail_data(fdata[0]));

  store_sequence_monitor #(.NUM_EXP(4), .TIMEOUT(16), .ORDERED(1'b0)) u_uno (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_count(exp_count), .start(start), .clear(clear),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[1]), .pass(pass[1]), .fail_code(fcode[1]), .match_count(mcnt[1]),
    .cycles(cyc[1]), .fail_addr(faddr[1]), .fail_data(fdata[1]));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // mask bit 0 -> ordered instance, bit 1 -> unordered instance
  task automatic push(input int mask, input bit p, input bit [1:0] fc, input int mc,
                      input int cy, input int fa, input int fd);
    res_t r;
    r.pass = p; r.fc = fc; r.mc = mc; r.cyc = cy; r.fa = fa; r.fd = fd;
    if (mask[0]) q0.push_back(r);
    if (mask[1]) q1.push_back(r);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k] && !done_prev[k]) begin
        if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL d%0d_unexpected_done got fail_code %0d expected no verdict", k, fcode[k]);
        end else begin
          res_t e;
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("d%0d_pass", k),      pass[k],  e.pass);
          chk($sformatf("d%0d_fail_code", k), fcode[k], e.fc);
          chk($sformatf("d%0d_match_cnt", k), mcnt[k],  e.mc);
          chk($sformatf("d%0d_cycles", k),    cyc[k],   e.cyc);
          chk($sformatf("d%0d_fail_addr", k), faddr[k], e.fa);
          chk($sformatf("d%0d_fail_data", k), fdata[k], e.fd);
        end
      end
      done_prev[k] = done[k];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input int a, input int d);
    exp_we = 1'b1; exp_idx = IDX_W'(idx); exp_addr = a; exp_data = d;
    step();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    exp_count = (IDX_W+1)'(n); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_d%0d_done", tag, k),  done[k],  1'b0);
      chk($sformatf("%s_d%0d_pass", tag, k),  pass[k],  1'b0);
      chk($sformatf("%s_d%0d_fcode", tag, k), fcode[k], 2'd0);
      chk($sformatf("%s_d%0d_mcnt", tag, k),  mcnt[k],  0);
      chk($sformatf("%s_d%0d_cyc", tag, k),   cyc[k],   0);
      chk($sformatf("%s_d%0d_faddr", tag, k), faddr[k], 0);
    end
  endtask

  initial begin
    reset = 1'b0; exp_we = 1'b0; start = 1'b0; clear = 1'b0; memwrite = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0; dataadr = '0; writedata = '0; exp_count = '0;
    repeat (2) step();
    chk_idle("reset");
    reset = 1'b1;
    step();

    // ordered pass through scratch stores
    load(0, 84, 7);
    push(3, 1'b1, 2'd0, 1, 3, 0, 0);
    start_run(1);
    store(80, 3);
    store(80, 5);
    chk("pre_final_done", done[0], 1'b0);
    store(84, 7);
    chk("post_final_done", done[0], 1'b1);
    do_clear();
    chk_idle("clear1");

    // mismatch, later correct store ignored
    push(3, 1'b0, 2'd1, 0, 1, 88, 7);
    start_run(1);
    store(88, 7);
    store(84, 7);
    chk("held_pass", pass[0], 1'b0);
    chk("held_cycles", cyc[1], 1);
    do_clear();

    // out-of-order stores: unordered passes, ordered fails on first
    load(1, 88, 9);
    push(1, 1'b0, 2'd1, 0, 1, 88, 9);
    push(2, 1'b1, 2'd0, 2, 2, 0, 0);
    start_run(2);
    store(88, 9);
    store(84, 7);
    do_clear();

    // repeated store to an already-satisfied entry
    push(3, 1'b0, 2'd1, 1, 2, 84, 7);
    start_run(2);
    store(84, 7);
    store(84, 7);
    do_clear();

    // timeout with no stores
    push(3, 1'b0, 2'd2, 0, 16, 0, 0);
    start_run(1);
    for (int i = 0; i < 40 && !(done[0] && done[1]); i++) step();
    do_clear();

    // final-edge priority: match, mismatch, and scratch (still times out)
    push(3, 1'b1, 2'd0, 1, 16, 0, 0);
    start_run(1);
    repeat (15) step();
    store(84, 7);
    do_clear();
    push(3, 1'b0, 2'd1, 0, 16, 88, 7);
    start_run(1);
    repeat (15) step();
    store(88, 7);
    do_clear();
    push(3, 1'b0, 2'd2, 0, 16, 0, 0);
    start_run(1);
    repeat (15) step();
    store(80, 1);
    do_clear();

    // empty table passes immediately; table survives clear
    push(3, 1'b1, 2'd0, 0, 0, 0, 0);
    start_run(0);
    chk("empty_pass", pass[1], 1'b1);
    do_clear();
    chk_idle("clear2");
    push(3, 1'b1, 2'd0, 1, 1, 0, 0);
    start_run(1);
    store(84, 7);
    do_clear();

    // exp_count above table depth saturates to 4
    load(2, 92, 1);
    load(3, 96, 2);
    push(3, 1'b1, 2'd0, 4, 4, 0, 0);
    start_run(7);
    store(84, 7);
    store(88, 9);
    store(92, 1);
    store(96, 2);
    do_clear();

    // async reset mid-run
    start_run(2);
    store(84, 7);
    chk("pre_reset_mcnt", mcnt[0], 1);
    #2 reset = 1'b0;
    #1 chk_idle("async_reset");
    step();
    reset = 1'b1;
    store(84, 7);
    chk_idle("after_reset");
    load(0, 84, 7);
    push(3, 1'b1, 2'd0, 1, 1, 0, 0);
    start_run(1);
    store(84, 7);
    repeat (3) step();

    chk("q_ord_drained", q0.size(), 0);
    chk("q_uno_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
